// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: accepts a cipher key, derives round keys 1..NR one per clock
// into a register file, and serves them via a registered random-access read port.
// Latency: key accepted at E0, keys_valid/expand_done after E0+NR; read data 1 cycle after rk_rd_en.
// Backpressure: key_ready is low during expansion; key_valid is ignored (not buffered) then.

// One AES-128 key-expansion step: next round key from the previous one and its round index.
module aes_round_key_gen (
  input  logic [127:0] i_key,
  input  logic [3:0]   i_round,
  output logic [127:0] o_key
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [7:0]  w_rcon;
  logic [31:0] w_rot;
  logic [31:0] w_temp;
  logic [31:0] w_n0;
  logic [31:0] w_n1;
  logic [31:0] w_n2;
  logic [31:0] w_n3;

  // Round constant; outside 1..10 it contributes nothing (never used there in EXPAND).
  always_comb begin
    w_rcon = 8'h00;
    case (i_round)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // RotWord of the last word, then SubWord, then Rcon into the top byte.
  assign w_rot  = {i_key[23:0], i_key[31:24]};
  assign w_temp = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]], SBOX[w_rot[15:8]], SBOX[w_rot[7:0]]}
                  ^ {w_rcon, 24'h000000};

  // Each new word chains off the previous new word.
  assign w_n0  = i_key[127:96] ^ w_temp;
  assign w_n1  = i_key[95:64]  ^ w_n0;
  assign w_n2  = i_key[63:32]  ^ w_n1;
  assign w_n3  = i_key[31:0]   ^ w_n2;
  assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

module aes_key_schedule #(
  parameter int NR         = 10,
  parameter bit REVERSE_RD = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         keys_valid,
  output logic         expand_done,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_rd_addr,
  output logic [127:0] rk_rd_data,
  output logic         rk_rd_vld
);

  // Only the AES-128 schedule is implemented.
  if (NR != 10) begin : g_bad_nr
    $error("aes_key_schedule: NR must be 10 (AES-128)");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_EXPAND = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_round;
  logic [3:0]   w_round_nxt;
  logic [127:0] r_cur_key;
  logic [127:0] w_cur_key_nxt;
  logic         r_keys_valid;
  logic         w_keys_valid_nxt;
  logic         r_expand_done;
  logic         w_expand_done_nxt;
  logic         w_rk_we;
  logic [3:0]   w_rk_waddr;
  logic [127:0] w_rk_wdata;
  logic [127:0] w_next_key;
  logic [127:0] r_rk [0:NR];
  logic [3:0]   w_rd_idx;
  logic         w_rd_zero;
  logic [127:0] r_rd_data;
  logic         r_rd_vld;

  aes_round_key_gen u_rkg (
    .i_key   (r_cur_key),
    .i_round (r_round),
    .o_key   (w_next_key)
  );

  // State and expansion control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_round       <= 4'd0;
      r_cur_key     <= '0;
      r_keys_valid  <= 1'b0;
      r_expand_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_round       <= w_round_nxt;
      r_cur_key     <= w_cur_key_nxt;
      r_keys_valid  <= w_keys_valid_nxt;
      r_expand_done <= w_expand_done_nxt;
    end
  end

  // Next-state logic: accept a key in IDLE, then one round key per cycle until round NR.
  always_comb begin
    w_state_nxt       = r_state;
    w_round_nxt       = r_round;
    w_cur_key_nxt     = r_cur_key;
    w_keys_valid_nxt  = r_keys_valid;
    w_expand_done_nxt = 1'b0;
    w_rk_we           = 1'b0;
    w_rk_waddr        = r_round;
    w_rk_wdata        = w_next_key;
    key_ready         = 1'b0;
    case (r_state)
      S_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          w_rk_we          = 1'b1;
          w_rk_waddr       = 4'd0;
          w_rk_wdata       = key_in;
          w_cur_key_nxt    = key_in;
          w_round_nxt      = 4'd1;
          w_keys_valid_nxt = 1'b0;
          w_state_nxt      = S_EXPAND;
        end
      end
      S_EXPAND: begin
        w_rk_we       = 1'b1;
        w_cur_key_nxt = w_next_key;
        if (r_round == NR_L) begin
          w_state_nxt       = S_IDLE;
          w_keys_valid_nxt  = 1'b1;
          w_expand_done_nxt = 1'b1;
          w_round_nxt       = 4'd0;
        end else begin
          w_round_nxt = r_round + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Round-key register file; reset clears any partially expanded schedule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) begin
        r_rk[i] <= '0;
      end
    end else if (w_rk_we) begin
      r_rk[w_rk_waddr] <= w_rk_wdata;
    end
  end

  // Read index mapping; out-of-range or incomplete schedules read as zero.
  assign w_rd_idx  = REVERSE_RD ? (NR_L - rk_rd_addr) : rk_rd_addr;
  assign w_rd_zero = (rk_rd_addr > NR_L) || !r_keys_valid;

  // Registered read port; data holds when no read is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_vld <= rk_rd_en;
      if (rk_rd_en) begin
        r_rd_data <= w_rd_zero ? '0 : r_rk[w_rd_idx];
      end
    end
  end

  assign keys_valid  = r_keys_valid;
  assign expand_done = r_expand_done;
  assign rk_rd_data  = r_rd_data;
  assign rk_rd_vld   = r_rd_vld;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: known-answer table, handshake/reset corner sequences,
// and random keys checked against an arithmetic AES key-expansion model.
// Two instances share all inputs: forward read order and reverse read order.
module tb_aes_key_schedule;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_addr;

  logic         key_ready, keys_valid, expand_done, rk_rd_vld;
  logic [127:0] rk_rd_data;
  logic         rv_key_ready, rv_keys_valid, rv_expand_done, rv_rk_rd_vld;
  logic [127:0] rv_rk_rd_data;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]   m_sbox [256];
  logic [127:0] m_rk [11];
  bit           m_valid = 1'b0;
  logic [127:0] last_f, last_r;

  aes_key_schedule #(.NR(10), .REVERSE_RD(1'b0)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .keys_valid(keys_valid), .expand_done(expand_done),
    .rk_rd_en(rk_rd_en), .rk_rd_addr(rk_rd_addr),
    .rk_rd_data(rk_rd_data), .rk_rd_vld(rk_rd_vld)
  );

  aes_key_schedule #(.NR(10), .REVERSE_RD(1'b1)) dut_rev (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(rv_key_ready), .keys_valid(rv_keys_valid), .expand_done(rv_expand_done),
    .rk_rd_en(rk_rd_en), .rk_rd_addr(rk_rd_addr),
    .rk_rd_data(rv_rk_rd_data), .rk_rd_vld(rv_rk_rd_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check_dat(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    d = d >> (8 - n);
    return d[7:0];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) (x^254) then affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
  endfunction

  // Word-level key expansion w[0..43]; round key r is w[4r..4r+3].
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = k[127:96];
    w[1] = k[95:64];
    w[2] = k[63:32];
    w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] exp_read(input bit rev, input int addr);
    if (!m_valid || addr > 10) return '0;
    return rev ? m_rk[10 - addr] : m_rk[addr];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_key(input logic [127:0] k);
    int c;
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    c = 0;
    while (!key_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    check_bit("accept_ready", key_ready, 1'b1);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    m_valid   = 1'b0;
    model_expand(k);
    check_bit("ready_low_at_accept", key_ready, 1'b0);
    check_bit("keys_valid_drop", keys_valid, 1'b0);
    for (c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (expand_done) break;
    end
    check_int("expand_latency", c, 10);
    m_valid = 1'b1;
    check_bit("keys_valid_set", keys_valid, 1'b1);
    check_bit("rev_keys_valid", rv_keys_valid, 1'b1);
    check_bit("ready_after_done", key_ready, 1'b1);
    @(posedge clk);
    #1;
    check_bit("done_one_pulse", expand_done, 1'b0);
    check_bit("rev_done_one_pulse", rv_expand_done, 1'b0);
  endtask

  task automatic read_chk(input int addr);
    @(negedge clk);
    rk_rd_en   = 1'b1;
    rk_rd_addr = 4'(addr);
    @(posedge clk);
    #1;
    last_f = exp_read(1'b0, addr);
    last_r = exp_read(1'b1, addr);
    check_bit($sformatf("rd_vld_a%0d", addr), rk_rd_vld, 1'b1);
    check_bit($sformatf("rev_rd_vld_a%0d", addr), rv_rk_rd_vld, 1'b1);
    check_dat($sformatf("rd_fwd_a%0d", addr), rk_rd_data, last_f);
    check_dat($sformatf("rd_rev_a%0d", addr), rv_rk_rd_data, last_r);
  endtask

  task automatic hold_chk();
    @(negedge clk);
    rk_rd_en = 1'b0;
    @(posedge clk);
    #1;
    check_bit("idle_vld_low", rk_rd_vld, 1'b0);
    check_dat("idle_data_hold", rk_rd_data, last_f);
    check_dat("idle_rev_data_hold", rv_rk_rd_data, last_r);
  endtask

  task automatic read_all();
    for (int a = 0; a <= 10; a++) read_chk(a);
    hold_chk();
  endtask

  // ---------------- known-answer table ----------------
  typedef struct {
    logic [127:0] key;
    bit           rev;
    logic [3:0]   addr;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_ZERO = 128'h0;

  vec_t vecs [9];

  initial begin
    logic [127:0] loaded;
    bit           have_loaded;
    logic [127:0] ka, kb, got, old_f;
    int           c;

    rst        = 1'b1;
    key_in     = '0;
    key_valid  = 1'b0;
    rk_rd_en   = 1'b0;
    rk_rd_addr = 4'd0;
    have_loaded = 1'b0;
    loaded      = '0;

    for (int x = 0; x < 256; x++) m_sbox[x] = sbox_calc(8'(x));

    vecs[0] = '{K_FIPS, 1'b0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1] = '{K_FIPS, 1'b0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{K_FIPS, 1'b0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{K_FIPS, 1'b0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{K_FIPS, 1'b1, 4'd0,  128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[5] = '{K_FIPS, 1'b1, 4'd10, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[6] = '{K_ZERO, 1'b0, 4'd1,  128'h62636363626363636263636362636363};
    vecs[7] = '{K_ZERO, 1'b0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[8] = '{K_ZERO, 1'b1, 4'd0,  128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_keys_valid", keys_valid, 1'b0);
    check_bit("rst_done", expand_done, 1'b0);
    check_bit("rst_rd_vld", rk_rd_vld, 1'b0);
    check_dat("rst_rd_data", rk_rd_data, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_bit("post_rst_ready", key_ready, 1'b1);
    check_bit("post_rst_keys_valid", keys_valid, 1'b0);

    // Reads before any key: valid strobe, zero data (including out-of-range).
    read_chk(0);
    read_chk(11);

    // Known-answer vectors.
    for (int i = 0; i < 9; i++) begin
      if (!have_loaded || loaded !== vecs[i].key) begin
        load_key(vecs[i].key);
        loaded      = vecs[i].key;
        have_loaded = 1'b1;
      end
      @(negedge clk);
      rk_rd_en   = 1'b1;
      rk_rd_addr = vecs[i].addr;
      @(posedge clk);
      #1;
      got = vecs[i].rev ? rv_rk_rd_data : rk_rd_data;
      check_dat($sformatf("vec%0d", i), got, vecs[i].exp);
    end
    // Zero key still loaded: back-to-back reads of the whole schedule.
    read_all();

    // Out-of-range addresses with a valid schedule.
    read_chk(11);
    read_chk(15);
    hold_chk();

    // key_valid held through EXPAND with a different key: it is taken only at E0+11,
    // and a read on that accept edge still sees the old schedule.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    key_in    = ka;
    key_valid = 1'b1;
    check_bit("t3_ready_idle", key_ready, 1'b1);
    @(posedge clk);
    #1;
    key_in  = kb;
    m_valid = 1'b0;
    model_expand(ka);
    check_bit("t3_ready_e0", key_ready, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (i < 10) begin
        check_bit($sformatf("t3_ready_low_c%0d", i), key_ready, 1'b0);
      end else begin
        check_bit("t3_done_c10", expand_done, 1'b1);
        check_bit("t3_ready_c10", key_ready, 1'b1);
      end
    end
    m_valid = 1'b1;
    @(negedge clk);
    rk_rd_en   = 1'b1;
    rk_rd_addr = 4'd10;
    old_f = exp_read(1'b0, 10);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    rk_rd_en  = 1'b0;
    check_dat("t3_read_old_keys", rk_rd_data, old_f);
    check_bit("t3_second_accept", key_ready, 1'b0);
    check_bit("t3_valid_drop", keys_valid, 1'b0);
    m_valid = 1'b0;
    model_expand(kb);
    for (c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (expand_done) break;
    end
    check_int("t3_second_latency", c, 10);
    m_valid = 1'b1;
    read_all();

    // Reset in the middle of an expansion discards everything.
    @(negedge clk);
    key_in    = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    m_valid = 1'b0;
    check_bit("t4_keys_valid", keys_valid, 1'b0);
    check_bit("t4_ready", key_ready, 1'b1);
    check_bit("t4_rd_vld", rk_rd_vld, 1'b0);
    check_dat("t4_rd_data", rk_rd_data, '0);
    #1;
    rst = 1'b0;
    read_all();
    load_key(K_FIPS);
    read_all();

    // Random keys against the model.
    for (int n = 0; n < 8; n++) begin
      load_key({$urandom, $urandom, $urandom, $urandom});
      read_all();
      read_chk(int'($urandom_range(11, 15)));
      hold_chk();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
